// File: rtl/r5p_bus_pkg.sv
// Shared helpers for the system bus arbiter: width of a manager-port index.
package r5p_bus_pkg;

    function automatic int iw(input int bn);
        return (bn <= 1) ? 1 : $clog2(bn);
    endfunction

endpackage

// File: rtl/r5p_bus_if.sv
// System bus interface: manager drives the request payload, subordinate answers with rdy and rdt.
// Valid/ready: a transfer happens on a cycle with vld & rdy; for a read (wen=0) rdt is valid the next cycle.
interface r5p_bus_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic            vld;
    logic            wen;
    logic [DW/8-1:0] ben;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   wdt;
    logic [DW-1:0]   rdt;
    logic            rdy;

    modport man (output vld, wen, ben, adr, wdt, input  rdt, rdy);
    modport sub (input  vld, wen, ben, adr, wdt, output rdt, rdy);
endinterface

// File: rtl/r5p_arb_rr.sv
// Combinational grant selection: round-robin from ptr when R5P_BUS_ARB_RR_EN is defined,
// otherwise fixed priority with the lowest index winning.
module r5p_arb_rr
    import r5p_bus_pkg::*;
#(
    parameter  int BN = 2,
    localparam int IW = iw(BN)
) (
    input  logic [BN-1:0] req,
`ifdef R5P_BUS_ARB_RR_EN
    input  logic [IW-1:0] ptr,
`endif
    output logic [BN-1:0] gnt,
    output logic [IW-1:0] idx
);

`ifdef R5P_BUS_ARB_RR_EN
    function automatic logic [IW-1:0] rot(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= BN) s = s - BN;
        return IW'(s);
    endfunction
`endif

    // Scan from the lowest priority upward so the highest-priority requester is written last.
    always_comb begin
        gnt = '0;
        idx = '0;
`ifdef R5P_BUS_ARB_RR_EN
        for (int k = BN - 1; k >= 0; k--) begin
            if (req[rot(ptr, k)]) begin
                gnt              = '0;
                gnt[rot(ptr, k)] = 1'b1;
                idx              = rot(ptr, k);
            end
        end
`else
        for (int k = BN - 1; k >= 0; k--) begin
            if (req[k]) begin
                gnt    = '0;
                gnt[k] = 1'b1;
                idx    = IW'(k);
            end
        end
`endif
    end

endmodule

// File: rtl/r5p_bus_arb.sv
// Merges BN bus managers onto one subordinate: zero-latency forward mux, grant lock while stalled,
// read data routed back one cycle later. R5P_BUS_ARB_RR_EN selects round-robin over fixed priority.
module r5p_bus_arb
    import r5p_bus_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int BN = 2
) (
    input  logic      clk,
    input  logic      rst,
    r5p_bus_if.sub    s [BN-1:0],
    r5p_bus_if.man    m
);
    localparam int IW = iw(BN);

    logic [BN-1:0]                 req;
    logic [BN-1:0]                 wen_a;
    logic [BN-1:0][DW/8-1:0]       ben_a;
    logic [BN-1:0][AW-1:0]         adr_a;
    logic [BN-1:0][DW-1:0]         wdt_a;
    logic [IW-1:0]                 sel;
    logic [BN-1:0]                 sel_oh;
    logic                          xfer;
    logic                          rsp_vld_q, rsp_vld_d;
    logic [IW-1:0]                 rsp_idx_q, rsp_idx_d;

    // Outputs towards managers are forced quiet while reset is asserted.
    for (genvar gi = 0; gi < BN; gi++) begin : g_port
        assign req[gi]   = s[gi].vld;
        assign wen_a[gi] = s[gi].wen;
        assign ben_a[gi] = s[gi].ben;
        assign adr_a[gi] = s[gi].adr;
        assign wdt_a[gi] = s[gi].wdt;
        assign s[gi].rdy = rst & m.rdy & sel_oh[gi];
        assign s[gi].rdt = (rst && rsp_vld_q && (rsp_idx_q == IW'(gi))) ? m.rdt : '0;
    end

    assign m.vld = rst & (|req);
    assign m.wen = wen_a[sel];
    assign m.ben = ben_a[sel];
    assign m.adr = adr_a[sel];
    assign m.wdt = wdt_a[sel];
    assign xfer  = m.vld & m.rdy;

    if (BN == 1) begin : g_single
        assign sel    = '0;
        assign sel_oh = '1;
    end else begin : g_multi
        logic          lock_q, lock_d;
        logic [IW-1:0] lck_idx_q, lck_idx_d;
        logic [BN-1:0] arb_gnt;
        logic [IW-1:0] arb_idx;
`ifdef R5P_BUS_ARB_RR_EN
        logic [IW-1:0] ptr_q, ptr_d;
`endif

        r5p_arb_rr #(.BN(BN)) u_arb (
            .req (req),
`ifdef R5P_BUS_ARB_RR_EN
            .ptr (ptr_q),
`endif
            .gnt (arb_gnt),
            .idx (arb_idx)
        );

        // A stalled grant is frozen until its transfer completes.
        always_comb begin
            sel       = lock_q ? lck_idx_q : arb_idx;
            sel_oh    = arb_gnt;
            lock_d    = lock_q;
            lck_idx_d = lck_idx_q;
            if (lock_q) begin
                sel_oh            = '0;
                sel_oh[lck_idx_q] = 1'b1;
            end
            if (xfer) begin
                lock_d = 1'b0;
            end else if (m.vld) begin
                lock_d    = 1'b1;
                lck_idx_d = sel;
            end
`ifdef R5P_BUS_ARB_RR_EN
            ptr_d = ptr_q;
            if (xfer) ptr_d = (sel == IW'(BN - 1)) ? '0 : sel + 1'b1;
`endif
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                lock_q    <= 1'b0;
                lck_idx_q <= '0;
`ifdef R5P_BUS_ARB_RR_EN
                ptr_q     <= '0;
`endif
            end else begin
                lock_q    <= lock_d;
                lck_idx_q <= lck_idx_d;
`ifdef R5P_BUS_ARB_RR_EN
                ptr_q     <= ptr_d;
`endif
            end
        end
    end

    always_comb begin
        rsp_vld_d = xfer;
        rsp_idx_d = sel;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_vld_q <= 1'b0;
            rsp_idx_q <= '0;
        end else begin
            rsp_vld_q <= rsp_vld_d;
            rsp_idx_q <= rsp_idx_d;
        end
    end

endmodule

// File: tb/tb_r5p_bus_arb.sv
// Bench for r5p_bus_arb: directed scenarios then random traffic, checked by a scoreboard fed from a
// behavioural arbitration model and a bench-side subordinate memory.
module tb_r5p_bus_arb;
  localparam int BN = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0;

  // stimulus signals
  logic [BN-1:0] d_vld = '0;
  logic [BN-1:0] d_wen = '0;
  logic [3:0]    d_ben [BN];
  logic [31:0]   d_adr [BN];
  logic [31:0]   d_wdt [BN];
  logic          m_rdy = 1'b0;
  logic [BN-1:0] o_rdy;
  logic [31:0]   o_rdt [BN];

  r5p_bus_if #(.AW(32), .DW(32)) s_if [BN-1:0] ();
  r5p_bus_if #(.AW(32), .DW(32)) m_if ();

  for (genvar g = 0; g < BN; g++) begin : g_port
    assign s_if[g].vld = d_vld[g];
    assign s_if[g].wen = d_wen[g];
    assign s_if[g].ben = d_ben[g];
    assign s_if[g].adr = d_adr[g];
    assign s_if[g].wdt = d_wdt[g];
    assign o_rdy[g]    = s_if[g].rdy;
    assign o_rdt[g]    = s_if[g].rdt;
  end

  r5p_bus_arb #(.AW(32), .DW(32), .BN(BN)) dut (
    .clk (clk),
    .rst (rst),
    .s   (s_if),
    .m   (m_if)
  );

  // bench-side subordinate: memory with one-cycle read data, garbage on rdt otherwise
  logic [31:0] sub_mem [256];
  logic [31:0] sub_rdt = '0;
  logic [31:0] sub_w;
  assign m_if.rdy = m_rdy;
  assign m_if.rdt = sub_rdt;

  always @(posedge clk) begin
    if (m_if.vld && m_if.rdy) begin
      if (m_if.wen) begin
        sub_w = sub_mem[m_if.adr[9:2]];
        for (int b = 0; b < 4; b++)
          if (m_if.ben[b]) sub_w[8*b +: 8] = m_if.wdt[8*b +: 8];
        sub_mem[m_if.adr[9:2]] <= sub_w;
        sub_rdt <= $urandom;
      end else begin
        sub_rdt <= sub_mem[m_if.adr[9:2]];
      end
    end else begin
      sub_rdt <= $urandom;
    end
  end

  // scoreboard
  typedef struct packed {
    logic [31:0]   cyc;
    logic          rst;
    logic [BN-1:0] vld;
    logic          mvld;
    logic [BN-1:0] rdy;
    logic          wen;
    logic [3:0]    ben;
    logic [31:0]   adr;
    logic [31:0]   wdt;
  } fwd_t;
  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  port;
    logic        wr;
    logic [31:0] data;
  } rsp_t;
  fwd_t fwd_q[$];
  rsp_t rsp_q[$];
  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // reference model: arbitration rules stated as plain integer arithmetic
  logic [31:0] ref_mem [256];
  bit          lk = 0;
  int          lk_idx = 0;
  int          ptr = 0;
  int          drv_cyc = 0;
  bit          hold [BN];

  task automatic model_cycle();
    fwd_t e;
    rsp_t r;
    int   sel;
    logic [31:0] w;
    e = '0;
    e.cyc = drv_cyc;
    e.rst = rst;
    e.vld = d_vld;
    sel = -1;
    if (!rst) begin
      lk = 0; lk_idx = 0; ptr = 0;
      for (int i = 0; i < BN; i++) hold[i] = 0;
    end else begin
      if (d_vld != '0) begin
        if (lk) sel = lk_idx;
        else begin
`ifdef R5P_BUS_ARB_RR_EN
          for (int k = 0; k < BN; k++)
            if (sel < 0 && d_vld[(ptr + k) % BN]) sel = (ptr + k) % BN;
`else
          for (int k = 0; k < BN; k++)
            if (sel < 0 && d_vld[k]) sel = k;
`endif
        end
        e.mvld = 1'b1;
        e.rdy[sel] = m_rdy;
        e.wen = d_wen[sel];
        e.ben = d_ben[sel];
        e.adr = d_adr[sel];
        e.wdt = d_wdt[sel];
        if (m_rdy) begin
          lk = 0;
          ptr = (sel + 1) % BN;
          r.cyc = drv_cyc + 1;
          r.port = 8'(sel);
          r.wr = d_wen[sel];
          r.data = ref_mem[d_adr[sel][9:2]];
          if (d_wen[sel]) begin
            w = ref_mem[d_adr[sel][9:2]];
            for (int b = 0; b < 4; b++)
              if (d_ben[sel][b]) w[8*b +: 8] = d_wdt[sel][8*b +: 8];
            ref_mem[d_adr[sel][9:2]] = w;
          end
          rsp_q.push_back(r);
        end else begin
          lk = 1;
          lk_idx = sel;
        end
      end
      for (int i = 0; i < BN; i++) hold[i] = d_vld[i] && !(m_rdy && sel == i);
    end
    fwd_q.push_back(e);
    drv_cyc++;
  endtask

  // driver tasks: inputs change #1 after the rising edge
  task automatic drive(input logic r, input logic [BN-1:0] v, input logic [BN-1:0] w,
                       input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] wd,
                       input logic mr);
    @(posedge clk); #1;
    rst = r; d_vld = v; d_wen = w;
    d_adr[0] = a0; d_adr[1] = a1;
    d_wdt[0] = wd; d_wdt[1] = ~wd;
    d_ben[0] = 4'hF; d_ben[1] = 4'hF;
    m_rdy = mr;
    model_cycle();
  endtask

  task automatic drive_rand();
    @(posedge clk); #1;
    rst = ($urandom_range(0, 49) != 0);
    m_rdy = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < BN; i++) begin
      if (!hold[i]) begin
        d_vld[i] = ($urandom_range(0, 2) != 0);
        d_wen[i] = 1'($urandom_range(0, 1));
        d_adr[i] = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        d_wdt[i] = $urandom;
        d_ben[i] = 4'($urandom_range(0, 15));
      end
    end
    model_cycle();
  endtask

  // monitor: compares DUT outputs against the queued expectation at the falling edge
  fwd_t me;
  rsp_t mr_e;
  bit   due;
  logic [31:0] exp_rdt;
  initial begin
    forever begin
      @(negedge clk);
      if (fwd_q.size() > 0) begin
        me = fwd_q.pop_front();
        check("m_vld", 32'(m_if.vld), 32'(me.mvld));
        if (me.mvld) begin
          check("m_wen", 32'(m_if.wen), 32'(me.wen));
          check("m_ben", 32'(m_if.ben), 32'(me.ben));
          check("m_adr", m_if.adr, me.adr);
          check("m_wdt", m_if.wdt, me.wdt);
        end
        for (int i = 0; i < BN; i++)
          if (!me.rst || me.vld[i])
            check($sformatf("s%0d_rdy cyc %0d", i, me.cyc), 32'(o_rdy[i]), 32'(me.rdy[i]));
        due = (rsp_q.size() > 0) && (rsp_q[0].cyc == me.cyc);
        if (due) mr_e = rsp_q.pop_front();
        for (int i = 0; i < BN; i++) begin
          if (me.rst && due && mr_e.port == 8'(i) && mr_e.wr) continue;
          exp_rdt = (me.rst && due && mr_e.port == 8'(i)) ? mr_e.data : 32'd0;
          check($sformatf("s%0d_rdt cyc %0d", i, me.cyc), o_rdt[i], exp_rdt);
        end
      end
    end
  end

  // main sequence
  initial begin
    for (int i = 0; i < 256; i++) begin
      sub_mem[i] = 32'h5A5A_0000 ^ (i * 32'h0101_0101);
      ref_mem[i] = sub_mem[i];
    end
    sub_mem[8'h40] = 32'hAAAA_0000; ref_mem[8'h40] = 32'hAAAA_0000;
    sub_mem[8'h80] = 32'hBBBB_0000; ref_mem[8'h80] = 32'hBBBB_0000;
    for (int i = 0; i < BN; i++) begin
      d_ben[i] = '0; d_adr[i] = '0; d_wdt[i] = '0; hold[i] = 0;
    end

    // held in reset with both managers requesting
    repeat (3) drive(1'b0, 2'b11, 2'b00, 32'h100, 32'h200, 32'h0, 1'b1);
    // contention: both reading continuously
    repeat (4) drive(1'b1, 2'b11, 2'b00, 32'h100, 32'h200, 32'h0, 1'b1);
    drive(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1);
    // stall lock on port 1, port 0 joins while stalled
    drive(1'b1, 2'b10, 2'b00, 32'h100, 32'h200, 32'h0, 1'b0);
    drive(1'b1, 2'b11, 2'b00, 32'h100, 32'h200, 32'h0, 1'b0);
    drive(1'b1, 2'b11, 2'b00, 32'h100, 32'h200, 32'h0, 1'b0);
    drive(1'b1, 2'b11, 2'b00, 32'h100, 32'h200, 32'h0, 1'b1);
    drive(1'b1, 2'b01, 2'b00, 32'h100, 32'h200, 32'h0, 1'b1);
    drive(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1);
    // back-to-back write on port 0 then read on port 1 of the same word
    drive(1'b1, 2'b01, 2'b01, 32'h300, 32'h0, 32'h1234_5678, 1'b1);
    drive(1'b1, 2'b10, 2'b00, 32'h0, 32'h300, 32'h0, 1'b1);
    drive(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1);
    // reset right after a read transfer
    drive(1'b1, 2'b01, 2'b00, 32'h200, 32'h0, 32'h0, 1'b1);
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1);
    drive(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1);
    // random traffic
    repeat (3000) drive_rand();
    // drain
    for (int i = 0; i < 3; i++) drive(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    check("fwd_q_drained", 32'(fwd_q.size()), 32'd0);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/r5p_bus_arb.md
# r5p_bus_arb

System bus arbiter: merges BN system bus managers onto one shared subordinate (memory or peripheral), the counterpart of the bus decoder on the opposite side of the interconnect. It grants one requesting port per cycle, holds the grant while the subordinate stalls, and routes read data back to the port whose transfer produced it. Forward path is combinational (zero added latency); the read data return follows the bus rule of one cycle after the transfer.

## Interface
- AW, 32, address width
- DW, 32, data width; byte enable width is DW/8
- BN, 2, number of manager ports (≥1); IW = max(1, $clog2(BN))
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-low
- s[BN-1:0]  r5p_bus_if.sub  -  subordinate ports (manager devices connect here): vld, wen, ben, adr, wdt in; rdt, rdy out
- m  r5p_bus_if.man  -  manager port (shared subordinate connects here): vld, wen, ben, adr, wdt out; rdt, rdy in

## Operation
- Transfer on a port: vld & rdy in the same cycle; read data valid on rdt exactly one cycle after a transfer with wen=0.
- Arbitration: among ports with s[i].vld=1, select one (index sel). m.vld = OR of all s[i].vld; m.wen/ben/adr/wdt = s[sel] signals; 'x when no request.
- s[sel].rdy = m.rdy; s[i].rdy = 0 for all i≠sel.
- Lock: if m.vld & !m.rdy, register lock=1, lck_idx=sel; while lock=1, sel=lck_idx regardless of other requests. Lock clears on the transfer. Managers must keep vld and payload stable while stalled; arbiter does not check.
- Priority pointer ptr (IW bits): after each transfer ptr ← sel+1, wrapping BN-1 → 0. Search order ptr, ptr+1, …, wrapping.
- Read return: on each transfer, register rsp_vld=1, rsp_idx=sel; else rsp_vld=0. s[rsp_idx].rdt = m.rdt when rsp_vld; all other s[i].rdt = 0. Writes also set rsp_vld; rdt contents then don't-care.
- Back-to-back: transfer in cycle n on port A and cycle n+1 on port B is legal; rdt for A routed in n+1 concurrently with B's forward path.
- BN=1: sel constant 0; lock and ptr logic removed; behaves as wire plus rsp register.

## Timing
- Reset (rst=0 at posedge): lock=0, lck_idx=0, ptr=0, rsp_vld=0, rsp_idx=0. While rst=0, m.vld=0 and every s[i].rdy=0, s[i].rdt=0.
- Reset mid-operation: stalled request is dropped; read data pending for the cycle after reset is discarded (rsp_vld=0).
- Arbitration latency 0 cycles; read data latency 1 cycle after transfer; no bubbles between consecutive grants.
- Simultaneous transfer and new request on another port: new port served next cycle (pointer already advanced).
- Fairness: with all BN ports requesting continuously and m.rdy=1, each port gets exactly one transfer per BN cycles.

## Configuration
- R5P_BUS_ARB_RR_EN defined: round-robin via ptr as above.
- Undefined: fixed priority, lowest index wins; ptr register absent. Lock and read return unchanged.

## Structure
- r5p_bus_pkg: arbitration index type width helper (IW function), no bus typedefs beyond existing interface.
- Sub-module r5p_arb_rr: BN requests + ptr in, one-hot grant and encoded index out, purely combinational; fixed-priority variant selected inside it by the macro.
- Top holds lock, ptr, rsp registers and the muxes.

## Test plan
- Reset: hold rst=0 with s[0].vld=1, s[1].vld=1 → m.vld=0, all rdy=0; release → first grant port 0.
- Contention, BN=2, RR, m.rdy=1: both vld constant for 4 cycles → grants 0,1,0,1; reads to adr 0x100/0x200 return 0xAAAA_0000/0xBBBB_0000 to ports 0/1 one cycle later.
- Stall lock: port 1 read, m.rdy=0 for 3 cycles, port 0 raises vld in cycle 2 → grant stays 1, port 0 rdy=0; port 0 served cycle after release.
- Back-to-back: write port 0 (wdt 0x1234_5678, ben 0xF) then read port 1 next cycle → m sees both in order; port 0 rdt=0, port 1 rdt=m.rdt.
- Reset mid-read: transfer read on port 0, rst=0 next edge → s[0].rdt=0, no rsp delivered.
- Macro off: both ports requesting 4 cycles → port 0 granted every cycle, port 1 starved.
